edge_read_arbiter: RTL and testbench
====================================

// Module: edge_read_arbiter
// PURPOSE
//  Packet-aware round-robin scheduler for the edge router output port. Owns the one-hot
//  read-enable vector that feeds the OR-reduction read mux, so at most one input buffer
//  drives the mux per cycle. Holds a grant for a whole wormhole packet (head..tail flit).
//  Releases on tail, or on a MAX_FLITS overrun.
// PARAMETERS
//  NUM_PORTS  4   number of input buffers sharing the output mux (>=2)
//  MAX_FLITS  16  max flits per packet before forced release (>=1)
// PORTS
//  clk_i         in   1          single clock; all state on rising edge
//  rst_i         in   1          reset, asynchronous, active-high
//  req_i         in   NUM_PORTS  buffer k non-empty (head flit available)
//  tail_i        in   NUM_PORTS  head flit of buffer k is a tail flit (valid when req_i[k])
//  out_ready_i   in   1          downstream link accepts a flit this cycle
//  read_o        out  NUM_PORTS  one-hot pop / mux read_valid; at most one bit set
//  grant_o       out  NUM_PORTS  registered packet grant (one-hot or zero)
//  out_valid_o   out  1          mux output carries a valid flit this cycle
//  busy_o        out  1          state==LOCKED
//  err_o         out  1          1-cycle pulse on MAX_FLITS forced release
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, grant_q=0, prio_q=0, flit_cnt=0, err_o=0.
//  Reset forces read_o=0 and out_valid_o=0 combinationally.
//  Reset mid-packet abandons the packet; no recovery is attempted.
//  FSM: IDLE, LOCKED.
//  IDLE:
//   - read_o=0, out_valid_o=0.
//   - If |req_i, pick the first set req_i bit scanning prio_q, prio_q+1, ... mod NUM_PORTS.
//   - Register the pick into grant_q, clear flit_cnt, next state=LOCKED.
//   - Arbitration latency is 1 cycle: a req seen in IDLE is read at the earliest next cycle.
//  LOCKED (grant_q one-hot, index g):
//   - out_valid_o = req_i[g]
//   - read_o = grant_q & {NUM_PORTS{req_i[g] & out_ready_i}} (combinational)
//   - Transfer ("fire") = req_i[g] & out_ready_i; each fire increments flit_cnt.
//   - Fire with tail_i[g]=1: next state=IDLE, grant_q=0, prio_q=(g+1) mod NUM_PORTS.
//   - Fire with tail_i[g]=0 and flit_cnt+1==MAX_FLITS: forced release, same updates as
//     tail, err_o=1 for the following cycle.
//   - req_i[g]=0 (buffer underrun mid-packet): hold grant, no read, out_valid_o=0.
//     Other requesters stay blocked (wormhole); no timeout on stalls.
//   - out_ready_i=0: hold grant, no read, flit_cnt unchanged.
//   - Tail and MAX_FLITS reached on the same fire: normal tail release, err_o stays 0.
//  Packets are always separated by >=1 IDLE cycle (1 bubble per packet).
//  req_i/tail_i bits of non-granted ports are ignored while LOCKED.
//  flit_cnt width = $clog2(MAX_FLITS+1); never wraps (release happens at MAX_FLITS).
//  Invariant (assert): $onehot0(read_o); read_o is a subset of grant_o.
// TESTING
//  1 Reset: assert rst_i mid-sim with req_i=4'hF -> read_o, grant_o, busy_o, err_o =0
//    same cycle; after release, first grant goes to port 0.
//  2 From reset, req_i=4'b1010, tail_i=4'b1010, out_ready_i=1 -> grant_o=0010 next
//    cycle with read_o=0010; IDLE; then grant_o=1000, read_o=1000.
//  3 Fairness: req_i=4'hF, all tails, ready=1 -> grant order 0,1,2,3,0, each read
//    separated by one idle cycle.
//  4 3-flit packet on port 2, out_ready_i=0 for 3 cycles after grant -> read_o=0,
//    out_valid_o=1, grant held; then 3 reads, release on tail.
//  5 Underrun: req_i[g] drops for 2 cycles mid-packet while req_i[0]=1 -> out_valid_o=0,
//    grant unchanged, port 0 not serviced until tail.
//  6 MAX_FLITS=4, 6-flit packet no tail -> 4 reads, release, err_o pulse 1 cycle,
//    prio_q=g+1; remaining flits arbitrated as a new packet.

Source files
------------

// File: rtl/edge_read_arbiter_if.sv
// Read-side bundle between the input buffers, the arbiter and the output mux.
// The arbiter takes the slave view; buffers/link (or a bench) take the master view.
interface edge_read_arbiter_if #(
    parameter int NUM_PORTS = 4
);
    logic [NUM_PORTS-1:0] req_i;
    logic [NUM_PORTS-1:0] tail_i;
    logic                 out_ready_i;
    logic [NUM_PORTS-1:0] read_o;
    logic [NUM_PORTS-1:0] grant_o;
    logic                 out_valid_o;
    logic                 busy_o;
    logic                 err_o;

    modport slave (
        input  req_i, tail_i, out_ready_i,
        output read_o, grant_o, out_valid_o, busy_o, err_o
    );

    modport master (
        output req_i, tail_i, out_ready_i,
        input  read_o, grant_o, out_valid_o, busy_o, err_o
    );
endinterface

// File: rtl/edge_read_arbiter.sv
// Packet-aware round-robin read scheduler: holds a one-hot grant from head to tail flit
// and drives the one-hot read enable of the output OR-mux.
module edge_read_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int MAX_FLITS = 16
) (
    input logic                clk_i,
    input logic                rst_i,
    edge_read_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_FLITS + 1);
    localparam int PTR_W = $clog2(NUM_PORTS);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               r_state, w_state_nxt;
    logic [NUM_PORTS-1:0] r_grant, w_grant_nxt;
    logic [PTR_W-1:0]     r_prio,  w_prio_nxt;
    logic [CNT_W-1:0]     r_cnt,   w_cnt_nxt;
    logic                 r_err,   w_err_nxt;

    logic w_sel_req;
    logic w_sel_tail;
    logic w_fire;
    logic w_cnt_last;

    // First set request scanning upward from prio, wrapping around.
    function automatic logic [NUM_PORTS-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                     input logic [PTR_W-1:0]     prio);
        logic [NUM_PORTS-1:0] pick;
        logic                 found;
        logic [PTR_W-1:0]     idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = PTR_W'((int'(prio) + i) % NUM_PORTS);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [PTR_W-1:0] next_prio(input logic [NUM_PORTS-1:0] grant);
        logic [PTR_W-1:0] nxt;
        nxt = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) nxt = PTR_W'((i + 1) % NUM_PORTS);
        end
        return nxt;
    endfunction

    assign w_sel_req  = |(r_grant & bus.req_i);
    assign w_sel_tail = |(r_grant & bus.tail_i);
    assign w_fire     = (r_state == LOCKED) && w_sel_req && bus.out_ready_i;
    assign w_cnt_last = (r_cnt == CNT_W'(MAX_FLITS - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_prio  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_prio  <= w_prio_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_prio_nxt  = r_prio;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (|bus.req_i) begin
                    w_grant_nxt = rr_pick(bus.req_i, r_prio);
                    w_cnt_nxt   = '0;
                    w_state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                // Stalls (underrun or no ready) simply hold the grant; the wormhole blocks others.
                if (w_fire) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (w_sel_tail || w_cnt_last) begin
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                        w_prio_nxt  = next_prio(r_grant);
                        w_err_nxt   = !w_sel_tail;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.read_o      = (w_fire && !rst_i) ? r_grant : '0;
    assign bus.out_valid_o = (r_state == LOCKED) && w_sel_req && !rst_i;
    assign bus.grant_o     = r_grant;
    assign bus.busy_o      = (r_state == LOCKED);
    assign bus.err_o       = r_err;

    a_read_onehot_subset: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(bus.read_o) && ((bus.read_o & ~bus.grant_o) == '0));
endmodule

// File: tb/tb_edge_read_arbiter.sv
// Directed bench for edge_read_arbiter (4 ports, MAX_FLITS=4 so forced release is reachable).
module tb_edge_read_arbiter;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    edge_read_arbiter_if #(.NUM_PORTS(4)) bus ();

    edge_read_arbiter #(.NUM_PORTS(4), .MAX_FLITS(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Observation vector: grant[3:0], read[3:0], out_valid, busy, err
    logic [10:0] obs;
    assign obs = {bus.grant_o, bus.read_o, bus.out_valid_o, bus.busy_o, bus.err_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.req_i       = 4'b0000;
        bus.tail_i      = 4'b0000;
        bus.out_ready_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] exp;
        do_reset();
        #1;
        exp = 11'b0;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_state got=%b exp=%b", obs, exp);
        end
        bus.req_i = 4'hF; bus.tail_i = 4'hF; bus.out_ready_i = 1'b1;
        tick();
        #1;
        exp = {4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_pre_lock got=%b exp=%b", obs, exp);
        end
        rst = 1'b1;
        #1;
        exp = 11'b0;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_async_mid got=%b exp=%b", obs, exp);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_released_idle got=%b exp=%b", obs, exp);
        end
        tick();
        #1;
        exp = {4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_first_grant_p0 got=%b exp=%b", obs, exp);
        end
    endtask

    task automatic test_two_ports();
        logic [10:0] exp;
        do_reset();
        bus.req_i = 4'b1010; bus.tail_i = 4'b1010; bus.out_ready_i = 1'b1;
        #1;
        exp = 11'b0;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL two_idle_latency got=%b exp=%b", obs, exp);
        end
        tick();
        #1;
        exp = {4'b0010, 4'b0010, 1'b1, 1'b1, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL two_grant_p1 got=%b exp=%b", obs, exp);
        end
        tick();
        #1;
        exp = 11'b0;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL two_bubble got=%b exp=%b", obs, exp);
        end
        tick();
        #1;
        exp = {4'b1000, 4'b1000, 1'b1, 1'b1, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL two_grant_p3 got=%b exp=%b", obs, exp);
        end
    endtask

    task automatic test_fairness();
        logic [10:0] exp;
        logic [3:0]  oh;
        do_reset();
        bus.req_i = 4'hF; bus.tail_i = 4'hF; bus.out_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            tick();
            #1;
            exp = {oh, oh, 1'b1, 1'b1, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL fair_grant_%0d got=%b exp=%b", k, obs, exp);
            end
            tick();
            #1;
            exp = 11'b0;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL fair_bubble_%0d got=%b exp=%b", k, obs, exp);
            end
        end
    endtask

    task automatic test_stall();
        logic [10:0] exp;
        do_reset();
        bus.req_i = 4'b0100; bus.tail_i = 4'b0000; bus.out_ready_i = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            exp = {4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL stall_hold_%0d got=%b exp=%b", k, obs, exp);
            end
            tick();
        end
        bus.out_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) bus.tail_i = 4'b0100;
            #1;
            exp = {4'b0100, 4'b0100, 1'b1, 1'b1, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL stall_read_%0d got=%b exp=%b", k, obs, exp);
            end
            tick();
        end
        #1;
        exp = 11'b0;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL stall_release got=%b exp=%b", obs, exp);
        end
    endtask

    task automatic test_underrun();
        logic [10:0] exp;
        do_reset();
        bus.req_i = 4'b0100; bus.tail_i = 4'b0000; bus.out_ready_i = 1'b1;
        tick();
        #1;
        exp = {4'b0100, 4'b0100, 1'b1, 1'b1, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL under_first got=%b exp=%b", obs, exp);
        end
        tick();
        bus.req_i = 4'b0001;
        for (int k = 0; k < 2; k++) begin
            #1;
            exp = {4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL under_gap_%0d got=%b exp=%b", k, obs, exp);
            end
            tick();
        end
        bus.req_i = 4'b0101; bus.tail_i = 4'b0100;
        #1;
        exp = {4'b0100, 4'b0100, 1'b1, 1'b1, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL under_tail got=%b exp=%b", obs, exp);
        end
        tick();
        #1;
        exp = 11'b0;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL under_release got=%b exp=%b", obs, exp);
        end
        tick();
        #1;
        exp = {4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL under_next_p0 got=%b exp=%b", obs, exp);
        end
    endtask

    task automatic test_max_flits();
        logic [10:0] exp;
        do_reset();
        bus.req_i = 4'b0010; bus.tail_i = 4'b0000; bus.out_ready_i = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            #1;
            exp = {4'b0010, 4'b0010, 1'b1, 1'b1, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL max_read_%0d got=%b exp=%b", k, obs, exp);
            end
            tick();
        end
        #1;
        exp = {4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL max_forced_err got=%b exp=%b", obs, exp);
        end
        tick();
        #1;
        exp = {4'b0010, 4'b0010, 1'b1, 1'b1, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL max_regrant got=%b exp=%b", obs, exp);
        end
        tick();
        bus.tail_i = 4'b0010;
        #1;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL max_last_flit got=%b exp=%b", obs, exp);
        end
        tick();
        #1;
        exp = 11'b0;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL max_tail_release got=%b exp=%b", obs, exp);
        end
    endtask

    task automatic test_tail_at_max();
        logic [10:0] exp;
        do_reset();
        bus.req_i = 4'b1000; bus.tail_i = 4'b0000; bus.out_ready_i = 1'b1;
        tick();
        tick();
        tick();
        tick();
        bus.tail_i = 4'b1000;
        #1;
        exp = {4'b1000, 4'b1000, 1'b1, 1'b1, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL tailmax_fourth got=%b exp=%b", obs, exp);
        end
        tick();
        #1;
        exp = 11'b0;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL tailmax_no_err got=%b exp=%b", obs, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.req_i = 4'b0000;
        bus.tail_i = 4'b0000;
        bus.out_ready_i = 1'b0;
        test_reset();
        test_two_ports();
        test_fairness();
        test_stall();
        test_underrun();
        test_max_flits();
        test_tail_at_max();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
